// File: rtl/mod_inv_param.sv
// Modular division engine: a * b^-1 * 2^s mod n via Kaliski almost-inverse
// followed by a run-time power-of-two correction of the 2^k factor.
module mod_inv_param #(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned CW    = $clog2(2*WIDTH+1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_n,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [CW-1:0]    i_shift,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_error,
  output logic [WIDTH-1:0] o_result
);

  localparam int unsigned RW   = WIDTH + 1;
  localparam int unsigned EW   = WIDTH + 2;
  localparam int unsigned KMAX = 2 * WIDTH;

  typedef enum logic [2:0] {IDLE, PH1, FIX, ADJ, DONE} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] n_q, n_d, u_q, u_d, v_q, v_d;
  logic [RW-1:0]    r_q, r_d, s_q, s_d;
  logic [CW-1:0]    k_q, k_d, shift_q, shift_d, d_q, d_d;
  logic             dir_q, dir_d, err_q, err_d;
  logic             busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             n_bad;
  logic [CW-1:0]    shift_sat;

  // 2x mod m with one conditional subtract; x < m on entry
  function automatic logic [RW-1:0] mod_dbl(input logic [RW-1:0] x, input logic [WIDTH-1:0] m);
    logic [EW-1:0] t;
    t = EW'(x) << 1;
    if (t >= EW'(m)) t = t - EW'(m);
    return RW'(t);
  endfunction

  function automatic logic [RW-1:0] mod_add(input logic [RW-1:0] x, input logic [RW-1:0] y,
                                            input logic [WIDTH-1:0] m);
    logic [EW-1:0] t;
    t = EW'(x) + EW'(y);
    if (t >= EW'(m)) t = t - EW'(m);
    return RW'(t);
  endfunction

  // x/2 mod m for odd m: add m first when x is odd
  function automatic logic [RW-1:0] mod_half(input logic [RW-1:0] x, input logic [WIDTH-1:0] m);
    logic [EW-1:0] t;
    t = x[0] ? EW'(x) + EW'(m) : EW'(x);
    return RW'(t >> 1);
  endfunction

  assign n_bad     = ~i_n[0] || (i_n < WIDTH'(3));
  assign shift_sat = (i_shift > CW'(KMAX)) ? CW'(KMAX) : i_shift;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (i_start) state_d = n_bad ? DONE : PH1;
      PH1:  if (v_q == '0) state_d = FIX;
      FIX: begin
        if (u_q != WIDTH'(1))      state_d = DONE;
        else if (k_q != shift_q)   state_d = ADJ;
        else                       state_d = DONE;
      end
      ADJ:  if (d_q == CW'(1)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    n_d      = n_q;
    u_d      = u_q;
    v_d      = v_q;
    r_d      = r_q;
    s_d      = s_q;
    k_d      = k_q;
    shift_d  = shift_q;
    d_d      = d_q;
    dir_d    = dir_q;
    err_d    = err_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    error_d  = error_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          n_d     = i_n;
          u_d     = i_n;
          v_d     = i_b;
          r_d     = '0;
          s_d     = RW'(i_a);
          k_d     = '0;
          shift_d = shift_sat;
          err_d   = n_bad;
          busy_d  = 1'b1;
        end
      end
      PH1: begin
        if (v_q != '0) begin
          k_d = k_q + CW'(1);
          if (!u_q[0]) begin
            u_d = u_q >> 1;
            s_d = mod_dbl(s_q, n_q);
          end else if (!v_q[0]) begin
            v_d = v_q >> 1;
            r_d = mod_dbl(r_q, n_q);
          end else if (u_q > v_q) begin
            u_d = (u_q - v_q) >> 1;
            r_d = mod_add(r_q, s_q, n_q);
            s_d = mod_dbl(s_q, n_q);
          end else begin
            v_d = (v_q - u_q) >> 1;
            s_d = mod_add(r_q, s_q, n_q);
            r_d = mod_dbl(r_q, n_q);
          end
        end
      end
      FIX: begin
        if (u_q != WIDTH'(1)) begin
          err_d = 1'b1;
        end else begin
          r_d = (r_q >= RW'(n_q)) ? r_q - RW'(n_q) : r_q;
          if (k_q > shift_q) begin
            d_d   = k_q - shift_q;
            dir_d = 1'b1;
          end else begin
            d_d   = shift_q - k_q;
            dir_d = 1'b0;
          end
        end
      end
      ADJ: begin
        d_d = d_q - CW'(1);
        r_d = dir_q ? mod_half(r_q, n_q) : mod_dbl(r_q, n_q);
      end
      DONE: begin
        done_d   = 1'b1;
        busy_d   = 1'b0;
        error_d  = err_q;
        result_d = (err_q || r_q == '0) ? '0 : WIDTH'(RW'(n_q) - r_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      n_q      <= '0;
      u_q      <= '0;
      v_q      <= '0;
      r_q      <= '0;
      s_q      <= '0;
      k_q      <= '0;
      shift_q  <= '0;
      d_q      <= '0;
      dir_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      result_q <= '0;
    end else begin
      n_q      <= n_d;
      u_q      <= u_d;
      v_q      <= v_d;
      r_q      <= r_d;
      s_q      <= s_d;
      k_q      <= k_d;
      shift_q  <= shift_d;
      d_q      <= d_d;
      dir_q    <= dir_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
      result_q <= result_d;
    end
  end

  assign o_busy   = busy_q;
  assign o_done   = done_q;
  assign o_error  = error_q;
  assign o_result = result_q;

endmodule

// File: tb/tb_mod_inv_param.sv
// Directed bench for mod_inv_param at WIDTH=8: result, error and done latency.
module tb_mod_inv_param;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 5;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_start;
  logic [W-1:0]  i_n, i_a, i_b;
  logic [CW-1:0] i_shift;
  logic          o_busy, o_done, o_error;
  logic [W-1:0]  o_result;

  mod_inv_param #(.WIDTH(W), .CW(CW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
    .i_n(i_n), .i_a(i_a), .i_b(i_b), .i_shift(i_shift),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_result(o_result)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [W-1:0]  n;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [CW-1:0] s;
    logic [W-1:0]  res;
    logic          err;
    int            lat;
  } vec_t;

  vec_t tv[13];
  vec_t tmp;
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t t);
    i_n     = t.n;
    i_a     = t.a;
    i_b     = t.b;
    i_shift = t.s;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    check("busy_after_accept", 32'(o_busy), 32'd1);
  endtask

  // count edges from accept to the o_done cycle; optionally disturb inputs mid-run
  task automatic wait_done(input vec_t t, input int disturb_at);
    int cnt = 0;
    int busy_bad = 0;
    bit seen = 1'b0;
    while (!seen && cnt < 200) begin
      @(posedge i_clk);
      cnt++;
      #1;
      if (cnt == disturb_at) begin
        i_n = 8'd14; i_a = 8'd5; i_b = 8'd2; i_shift = 5'd3; i_start = 1'b1;
      end else begin
        i_start = 1'b0;
      end
      if (o_done) seen = 1'b1;
      else if (!o_busy) busy_bad++;
    end
    check("done_latency", 32'(cnt), 32'(t.lat));
    check("result", 32'(o_result), 32'(t.res));
    check("error", 32'(o_error), 32'(t.err));
    check("busy_low_at_done", 32'(o_busy), 32'd0);
    check("busy_held_during_run", 32'(busy_bad), 32'd0);
  endtask

  task automatic after_done(input vec_t t);
    @(posedge i_clk);
    #1;
    check("done_single_cycle", 32'(o_done), 32'd0);
    check("result_held", 32'(o_result), 32'(t.res));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //         n      a      b      s      res    err   lat
    tv[0]  = '{8'd13, 8'd1,  8'd3,  5'd0,  8'd9,  1'b0, 11};
    tv[1]  = '{8'd13, 8'd1,  8'd3,  5'd8,  8'd3,  1'b0, 11};
    tv[2]  = '{8'd13, 8'd1,  8'd3,  5'd16, 8'd1,  1'b0, 19};
    tv[3]  = '{8'd13, 8'd1,  8'd3,  5'd4,  8'd1,  1'b0, 7};
    tv[4]  = '{8'd13, 8'd1,  8'd3,  5'd31, 8'd1,  1'b0, 19};
    tv[5]  = '{8'd11, 8'd5,  8'd7,  5'd0,  8'd7,  1'b0, 13};
    tv[6]  = '{8'd7,  8'd3,  8'd5,  5'd0,  8'd2,  1'b0, 11};
    tv[7]  = '{8'd7,  8'd3,  8'd5,  5'd2,  8'd1,  1'b0, 9};
    tv[8]  = '{8'd3,  8'd2,  8'd1,  5'd0,  8'd2,  1'b0, 7};
    tv[9]  = '{8'd15, 8'd1,  8'd6,  5'd0,  8'd0,  1'b1, 7};
    tv[10] = '{8'd14, 8'd1,  8'd3,  5'd0,  8'd0,  1'b1, 1};
    tv[11] = '{8'd13, 8'd1,  8'd0,  5'd0,  8'd0,  1'b1, 3};
    tv[12] = '{8'd1,  8'd0,  8'd0,  5'd0,  8'd0,  1'b1, 1};

    i_rst = 1'b0; i_start = 1'b0; i_n = '0; i_a = '0; i_b = '0; i_shift = '0;
    #12;
    check("reset_busy", 32'(o_busy), 32'd0);
    check("reset_done", 32'(o_done), 32'd0);
    check("reset_error", 32'(o_error), 32'd0);
    check("reset_result", 32'(o_result), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      apply(tv[i]);
      wait_done(tv[i], 0);
      after_done(tv[i]);
    end

    // back-to-back: new start in the o_done cycle, a=0 gives r==0
    apply(tv[5]);
    wait_done(tv[5], 0);
    tmp = tv[5];
    tmp.a = 8'd0;
    tmp.res = 8'd0;
    apply(tmp);
    wait_done(tmp, 0);
    after_done(tmp);

    // inputs changed and start re-pulsed mid-run
    apply(tv[0]);
    wait_done(tv[0], 3);
    after_done(tv[0]);

    // reset in PH1 aborts without a done pulse
    apply(tv[5]);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    #1;
    check("midrst_busy", 32'(o_busy), 32'd0);
    check("midrst_done", 32'(o_done), 32'd0);
    check("midrst_result", 32'(o_result), 32'd0);
    begin
      int done_seen = 0;
      for (int c = 0; c < 3; c++) begin
        @(posedge i_clk);
        #1;
        if (o_done) done_seen++;
      end
      check("midrst_no_done", 32'(done_seen), 32'd0);
    end
    @(negedge i_clk);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    apply(tv[1]);
    wait_done(tv[1], 0);
    after_done(tv[1]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_inv_param.md
# mod_inv_param

Parametrised modular-division / inversion engine for the ECC datapath. It computes a·b⁻¹·2^s mod n using the binary (Kaliski almost-inverse) algorithm, followed by a run-time-selectable power-of-two correction. s = 0 gives a plain modular quotient; s = WIDTH gives a Montgomery-domain result for direct hand-off to the Montgomery multiplier. It sits beside the point-add/double controller and adds input latching, detection of non-invertible operands, a busy/done handshake and an arbitrary correction exponent.

## Interface
- WIDTH, 256, operand/modulus width in bits
- CW, $clog2(2*WIDTH+1), width of iteration counters and of i_shift
- i_clk  in  1  clock, rising edge
- i_rst  in  1  asynchronous, active-low reset
- i_start  in  1  start request; sampled only in IDLE
- i_n  in  WIDTH  modulus; must be odd and ≥ 3, otherwise error
- i_a  in  WIDTH  numerator; caller guarantees a < n
- i_b  in  WIDTH  denominator; caller guarantees b < n
- i_shift  in  CW  correction exponent s; values > 2*WIDTH saturate to 2*WIDTH
- o_busy  out  1  high from the accepting edge until o_done
- o_done  out  1  one-cycle completion pulse
- o_error  out  1  valid with o_done: 1 = n invalid or gcd(b,n) ≠ 1
- o_result  out  WIDTH  a·b⁻¹·2^s mod n; 0 on error; held until the next accept

## Operation
- States: IDLE, PH1, FIX, ADJ, DONE.
- IDLE:
  - On i_start, latch n, a and s.
  - Load u=n, v=b, r=0, s_reg=a, k=0.
  - If n is even or n < 3, set err and go to DONE; otherwise go to PH1.
  - Set o_busy=1.
- PH1: one iteration per cycle while v ≠ 0, with k+1 each iteration.
  - u even: u=u/2; s_reg=2s_reg mod n.
  - Else v even: v=v/2; r=2r mod n.
  - Else u > v: u=(u−v)/2; r=(r+s_reg) mod n; s_reg=2s_reg mod n.
  - Else: v=(v−u)/2; s_reg=(r+s_reg) mod n; r=2r mod n.
  - The cycle that sees v == 0 goes to FIX.
- Arithmetic rules:
  - All "mod n" steps are a single conditional subtract (≥ n, not > n).
  - r, s_reg and the sums are held in WIDTH+1 bits; u, v and n in WIDTH bits.
  - k never exceeds 2*WIDTH.
- FIX:
  - If u ≠ 1, set err and go to DONE.
  - Else r = (r ≥ n) ? r−n : r. Set d=|k−s| and dir=(k > s). Go to ADJ if d ≠ 0, else DONE.
- ADJ: one step per cycle, d−1 each step; go to DONE when the last step executes.
  - dir=1 (halve): r = r odd ? (r+n)/2 : r/2.
  - dir=0 (double): r = 2r mod n.
- DONE:
  - o_result = err ? 0 : (r == 0 ? 0 : n−r).
  - o_error=err, o_done=1, o_busy=0. Return to IDLE.
- i_start while busy is ignored; latched operands are unaffected by input changes mid-run.

## Timing
- Reset values: o_busy=0, o_done=0, o_error=0, o_result=0, state=IDLE, all internal registers 0.
- Reset mid-operation aborts immediately, with no done pulse.
- Accepting edge is E0. o_done is high for exactly the cycle after edge E0+k+d+3 (valid path) or E0+k+3 (gcd error).
- Invalid n: o_done after E0+1 with o_error=1.
- o_result and o_error are registered and change only on the o_done edge.
- Back-to-back: i_start asserted during the o_done cycle is accepted (state is IDLE).
- Worst case latency: 2*WIDTH + 2*WIDTH + 3 cycles.

## Test plan
- WIDTH=8, n=13, a=1, b=3, s=0 -> o_result=9, o_error=0. o_busy is high from E0 until o_done; o_done is a single cycle.
- n=13, a=1, b=3, s=8 -> o_result=3 (Montgomery form of 9). Repeat with s=0 and s=16 to exercise both the halve and the double ADJ directions.
- n=11, a=5, b=7, s=0 -> o_result=7. Re-pulse i_start in the o_done cycle with a=0 -> o_result=0 (r==0 path), o_error=0.
- n=15, b=6 -> o_error=1, o_result=0. n=14 -> o_error=1 with o_done after E0+1. b=0, n=13 -> o_error=1.
- Change inputs and pulse i_start mid-run -> result still matches the first operands. Assert i_rst mid-PH1 -> all outputs 0, no o_done, next start runs correctly.
- Randomised WIDTH=256 operands against a reference model -> exact result match. Done timing equals k+d+3, with k ≤ 512.
